seg7_scan_mux: RTL

Consumes the slow square wave from the clock divider and multiplexes a packed hex value onto a common-anode 7-segment display, one digit per scan step. The divided clock is never used as a clock. It is synchronised into the clock_in domain and edge-detected into a one-cycle scan enable. The block sits between the CPU's debug/display register and the board display pins.

---
 rtl/seg7_scan_mux.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan_mux.sv
// Scans a packed hex value onto a common-anode 7-segment display, stepping on rising edges of a synchronised scan_in.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = 3
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      scan_in,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic                      scan_tick
);

    logic                      r_s1;
    logic                      r_s2;
    logic                      r_s2d;
    logic [1:0]                r_warm;
    logic                      w_tick;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_tick;
    logic [4*NUM_DIGITS-1:0]   r_disp;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_an;
    logic [6:0]                r_seg;
    logic                      r_dpo;
    logic [4*NUM_DIGITS-1:0]   w_disp_sh;
    logic [NUM_DIGITS-1:0]     w_dp_sh;
    logic [3:0]                w_nib;
    logic [6:0]                w_seg;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // For the first two edges after reset s2d follows s1, so a scan_in held
    // high across reset release brings s2 and s2d up together (no tick).
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2d  <= 1'b0;
            r_warm <= '0;
        end else begin
            r_s1   <= scan_in;
            r_s2   <= r_s1;
            r_s2d  <= r_warm[1] ? r_s2 : r_s1;
            r_warm <= {r_warm[0], 1'b1};
        end
    end

    assign w_tick = r_s2 & ~r_s2d;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_tick) begin
                if (r_idx == IDX_W'(NUM_DIGITS - 1))
                    r_idx <= '0;
                else
                    r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
            r_dp   <= '0;
        end else if (load) begin
            r_disp <= data_in;
            r_dp   <= dp_in;
        end
    end

    assign w_disp_sh = r_disp >> {r_idx, 2'b00};
    assign w_nib     = w_disp_sh[3:0];
    assign w_dp_sh   = r_dp >> r_idx;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_blank;

    // Blank when every nibble at or above the current digit is zero; digit 0 always shows.
    always_comb begin
        w_blank = (r_idx != '0);
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= 32'(r_idx)) && (r_disp[4*i +: 4] != 4'h0))
                w_blank = 1'b0;
        end
    end

    always_comb begin
        w_seg = w_blank ? 7'b1111111 : hex7(w_nib);
    end
`else
    always_comb begin
        w_seg = hex7(w_nib);
    end
`endif

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= '1;
            r_dpo <= 1'b1;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_seg;
            r_dpo <= ~w_dp_sh[0];
        end
    end

    assign an_out    = r_an;
    assign seg_out   = r_seg;
    assign dp_out    = r_dpo;
    assign scan_tick = r_tick;

endmodule
